i2c_codec_responder: RTL and testbench
======================================

# i2c_codec_responder

I2C write-only target that models the audio codec's control port, the far end of the I2C_AV_Config initiator. It decodes 3-byte codec register writes (device address, then 7-bit register address plus 9-bit data) and stores them in a register file. Each accepted write is strobed out, and the register file can be read back on a separate port. It sits beside the codec model in simulation and can also be placed on-chip to snoop and verify the configuration sequence.

## Interface
- DEV_ADDR, 7'h1A, 7-bit target address (write byte 0x34)
- NREGS, 16, number of implemented registers; legal register addresses are 0..NREGS-1
- RST_REG, 7'h0F, register address whose write clears the whole register file
- iCLK  in  1  system clock (50 MHz)
- iRST  in  1  reset, synchronous, active-high
- I2C_SCLK  in  1  bus clock, asynchronous to iCLK
- I2C_SDAT  inout  1  bus data, open-drain: driven 0 or released to 'z', never driven 1
- iRD_ADDR  in  4  register readback address
- oRD_DATA  out  9  registered readback data
- oWR_STB  out  1  one-cycle pulse per accepted register write
- oREG_ADDR  out  7  register address of the last accepted write
- oREG_DATA  out  9  data of the last accepted write
- oBUSY  out  1  high from START to STOP while the device address matches
- oNACK_CNT  out  8  saturating count of NACKed bytes

## Operation
- SCL and SDA input pass through a 2-FF synchronizer, then a 1-cycle-delayed copy is kept for edge detection.
- START is an SDA fall while SCL is high. STOP is an SDA rise while SCL is high. SDA is sampled on SCL rising edges, MSB first.
- States:
  - IDLE
  - ADDR: 8 bits
  - A_ACK
  - REG: byte 1, [7:1] = reg addr, [0] = data[8]
  - R_ACK
  - DATA: byte 2, data[7:0]
  - D_ACK
  - IGNORE
- START from any state goes to ADDR, clears the bit counter and discards any partial word. This covers repeated START.
- STOP from any state goes to IDLE and releases SDA.
- ADDR byte:
  - [7:1] == DEV_ADDR and R/W = 0: ACK, then REG.
  - R/W = 1: NACK, increment the NACK count, go to IGNORE.
  - Any other address: go to IGNORE silently, with no NACK count and SDA never driven.
- REG byte: ACK if the address is < NREGS or equals RST_REG. Otherwise NACK, increment the count, go to IGNORE.
- DATA byte: always ACK.
  - Commit the write on the SCL rising edge that samples bit 0 of the DATA byte.
  - Update the register, oREG_ADDR and oREG_DATA, and pulse oWR_STB.
  - A RST_REG write clears all NREGS entries to 0 instead of storing. oREG_ADDR and oREG_DATA still reflect the write.
- After D_ACK, any further byte is NACKed (count incremented) and the FSM goes to IGNORE. STOP then returns it to IDLE.
- ACK drive: pull SDA low starting at the SCL falling edge after the 8th bit, and release it at the next SCL falling edge. A NACK leaves SDA released.
- oNACK_CNT saturates at 255 and does not wrap.
- Readback: oRD_DATA equals regs[iRD_ADDR] one cycle later. Addresses ≥ NREGS read 0.

## Timing
- Reset values: state IDLE, SDA released, all registers 0, oWR_STB 0, oREG_ADDR 0, oREG_DATA 0, oBUSY 0, oNACK_CNT 0, oRD_DATA 0.
- A bus edge is recognized 3 iCLK cycles after the pin changes (2 synchronizer stages plus 1 edge stage).
- oWR_STB is high exactly on the cycle after the committing SCL rise is detected. The register file is updated on that same cycle.
- SDA ACK drive begins 1 cycle after the SCL fall is detected.
- Bus requirement: SCL high and low phases are each ≥ 4 iCLK cycles, and SDA changes only while SCL is low except for START and STOP. The bench must hold these.
- A write-commit and an iRD_ADDR read of the same register on the same cycle return the old value. The new value appears the following cycle.
- Reset asserted mid-transfer: SDA is released in the same cycle and the FSM goes to IDLE. The rest of that bus transaction is ignored until the next START.

## Test plan
- Send START, 0x34, 0x0C, 0x07, STOP. Require:
  - 3 ACKs
  - oWR_STB for 1 cycle with oREG_ADDR = 6 and oREG_DATA = 0x007
  - iRD_ADDR = 6 reads back 0x007
- Send 0x34, 0x05, 0xFF. Require reg 2 = 0x1FF, which checks that data bit 8 is taken from the REG byte.
- Address 0x36 frame: require no ACK, SDA never driven, no strobe, and oNACK_CNT unchanged. Address 0x35 (read): require NACK, oNACK_CNT = 1, and an ignored frame until STOP.
- Write reg 3 = 0x055, then write RST_REG (0x1E, 0x00). Require all readbacks = 0 and a strobe with oREG_ADDR = 0x0F.
- Send a REG byte with address 0x20: require NACK. Send a 4th byte after a valid write: require NACK and oNACK_CNT incremented. Send a repeated START after the REG byte: require the partial word discarded and the next full frame accepted.
- Assert iRST while SDA is driven for an ACK: require SDA = 'z' the same cycle, all outputs at reset values, and no strobe until a new START.

Source files
------------

// File: rtl/i2c_codec_responder_if.sv
// Host-side port bundle of the codec control-port responder.
//   iRD_ADDR   register readback address (host -> responder)
//   oRD_DATA   registered readback data, one cycle after iRD_ADDR
//   oWR_STB    one-cycle pulse per accepted register write
//   oREG_ADDR  register address of the last accepted write
//   oREG_DATA  data of the last accepted write
//   oBUSY      high while a frame addressed to this device is open
//   oNACK_CNT  saturating count of NACKed bytes
// master: the side that owns iRD_ADDR and watches the results.
// slave : the responder itself.
interface i2c_codec_responder_if;
  logic [3:0] iRD_ADDR;
  logic [8:0] oRD_DATA;
  logic       oWR_STB;
  logic [6:0] oREG_ADDR;
  logic [8:0] oREG_DATA;
  logic       oBUSY;
  logic [7:0] oNACK_CNT;

  modport master (
    output iRD_ADDR,
    input  oRD_DATA, oWR_STB, oREG_ADDR, oREG_DATA, oBUSY, oNACK_CNT
  );

  modport slave (
    input  iRD_ADDR,
    output oRD_DATA, oWR_STB, oREG_ADDR, oREG_DATA, oBUSY, oNACK_CNT
  );
endinterface

// File: rtl/i2c_codec_responder.sv
// i2c_codec_responder: write-only I2C target modelling the audio codec's
// control port. Decodes 3-byte writes (device address, {reg[6:0], data[8]},
// data[7:0]) into a register file, strobes each accepted write, and offers
// a registered readback port.
//   iCLK      system clock
//   iRST      synchronous active-high reset
//   I2C_SCLK  bus clock, asynchronous to iCLK
//   I2C_SDAT  open-drain bus data (driven 0 or released)
//   host      readback / write-report bundle (i2c_codec_responder_if.slave)
module i2c_codec_responder #(
  parameter logic [6:0]  DEV_ADDR = 7'h1A,
  parameter int unsigned NREGS    = 16,
  parameter logic [6:0]  RST_REG  = 7'h0F
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic I2C_SCLK,
  inout  wire  I2C_SDAT,
  i2c_codec_responder_if.slave host
);

  localparam int unsigned AW      = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [7:0]  NREGS_W = 8'(NREGS);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_A_ACK, S_REG, S_R_ACK, S_DATA, S_D_ACK, S_EXTRA, S_IGNORE
  } state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------------
  // Bus input synchronizers and edge detection
  // ---------------------------------------------------------------------
  logic [1:0] scl_sync, sda_sync;
  logic       scl_d, sda_d;
  logic       scl, sda;
  logic       scl_rise, scl_fall, start_det, stop_det;

  // Reset to the idle-bus level so leaving reset never fakes a START/STOP.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], I2C_SCLK};
      sda_sync <= {sda_sync[0], I2C_SDAT};
      scl_d    <= scl_sync[1];
      sda_d    <= sda_sync[1];
    end
  end

  assign scl       = scl_sync[1];
  assign sda       = sda_sync[1];
  assign scl_rise  = scl & ~scl_d;
  assign scl_fall  = ~scl & scl_d;
  assign start_det = scl & scl_d & ~sda & sda_d;
  assign stop_det  = scl & scl_d & sda & ~sda_d;

  // ---------------------------------------------------------------------
  // Datapath state
  // ---------------------------------------------------------------------
  logic [6:0]    shift_q;
  logic [3:0]    bit_cnt_q;     // 0..7 data bits, 8/9 inside the ACK clock
  logic          sda_low_q;
  logic          hit_q;
  logic [7:0]    nack_q;
  logic [6:0]    reg_addr_q;
  logic          data8_q;
  logic          wr_stb_q;
  logic [6:0]    wr_addr_q;
  logic [8:0]    wr_data_q;
  logic [8:0]    rd_data_q;
  logic [8:0]    regs [NREGS];

  logic [7:0]    byte_in;
  logic          last_bit, ack_done, bus_evt;
  logic          addr_hit, reg_ok, nack_evt, commit;
  logic          sda_oe, busy;
  logic [AW-1:0] rd_idx;
  logic          rd_ok;

  always_comb begin
    byte_in  = {shift_q, sda};
    bus_evt  = start_det | stop_det;
    last_bit = scl_rise && (bit_cnt_q == 4'd7);
    ack_done = scl_fall && (bit_cnt_q == 4'd9);
    addr_hit = (byte_in[7:1] == DEV_ADDR);
    reg_ok   = ({1'b0, byte_in[7:1]} < NREGS_W) || (byte_in[7:1] == RST_REG);
    nack_evt = last_bit && !bus_evt &&
               (((state_q == S_ADDR) && addr_hit && byte_in[0]) ||
                ((state_q == S_REG) && !reg_ok) ||
                (state_q == S_EXTRA));
    commit   = last_bit && !bus_evt && (state_q == S_DATA);
    rd_idx   = AW'(host.iRD_ADDR);
    rd_ok    = ({4'b0000, host.iRD_ADDR} < NREGS_W);
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge iCLK) begin
    if (iRST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  // S_EXTRA receives any byte after a completed write so it can be NACKed
  // and counted before the frame is ignored.
  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = S_ADDR;
    end else if (stop_det) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_ADDR:  if (last_bit) state_d = (addr_hit && !byte_in[0]) ? S_A_ACK : S_IGNORE;
        S_A_ACK: if (ack_done) state_d = S_REG;
        S_REG:   if (last_bit) state_d = reg_ok ? S_R_ACK : S_IGNORE;
        S_R_ACK: if (ack_done) state_d = S_DATA;
        S_DATA:  if (last_bit) state_d = S_D_ACK;
        S_D_ACK: if (ack_done) state_d = S_EXTRA;
        S_EXTRA: if (last_bit) state_d = S_IGNORE;
        default: state_d = state_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  // Reset gates the pull-down combinationally so SDA lets go in the very
  // cycle reset is raised, not one edge later.
  always_comb begin
    sda_oe = sda_low_q && !iRST;
    busy   = hit_q;
  end

  assign I2C_SDAT = sda_oe ? 1'b0 : 1'bz;

  // ---------------------------------------------------------------------
  // Shifter, ACK drive, counters, register file
  // ---------------------------------------------------------------------
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      sda_low_q  <= 1'b0;
      hit_q      <= 1'b0;
      nack_q     <= '0;
      reg_addr_q <= '0;
      data8_q    <= 1'b0;
      wr_stb_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_data_q  <= '0;
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      wr_stb_q  <= 1'b0;
      rd_data_q <= rd_ok ? regs[rd_idx] : '0;

      if (nack_evt && (nack_q != '1)) nack_q <= nack_q + 8'd1;

      if (start_det) begin
        shift_q   <= '0;
        bit_cnt_q <= '0;
        sda_low_q <= 1'b0;
        hit_q     <= 1'b0;
      end else if (stop_det) begin
        bit_cnt_q <= '0;
        sda_low_q <= 1'b0;
        hit_q     <= 1'b0;
      end else begin
        if (scl_rise) begin
          unique case (state_q)
            S_ADDR, S_REG, S_DATA, S_EXTRA: begin
              shift_q   <= byte_in[6:0];
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
            S_A_ACK, S_R_ACK, S_D_ACK: bit_cnt_q <= 4'd9;
            default: ;
          endcase
        end

        // ACK states are only entered when acknowledging: the first SCL
        // fall starts the pull-down, the fall after the 9th clock ends it.
        if (scl_fall && ((state_q == S_A_ACK) || (state_q == S_R_ACK) ||
                         (state_q == S_D_ACK))) begin
          if (bit_cnt_q == 4'd8) begin
            sda_low_q <= 1'b1;
          end else if (bit_cnt_q == 4'd9) begin
            sda_low_q <= 1'b0;
            bit_cnt_q <= '0;
          end
        end

        if (last_bit && (state_q == S_ADDR) && addr_hit && !byte_in[0])
          hit_q <= 1'b1;

        if (last_bit && (state_q == S_REG)) begin
          reg_addr_q <= byte_in[7:1];
          data8_q    <= byte_in[0];
        end
      end

      if (commit) begin
        wr_stb_q  <= 1'b1;
        wr_addr_q <= reg_addr_q;
        wr_data_q <= {data8_q, byte_in};
        if (reg_addr_q == RST_REG) begin
          for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
          regs[reg_addr_q[AW-1:0]] <= {data8_q, byte_in};
        end
      end
    end
  end

  assign host.oRD_DATA  = rd_data_q;
  assign host.oWR_STB   = wr_stb_q;
  assign host.oREG_ADDR = wr_addr_q;
  assign host.oREG_DATA = wr_data_q;
  assign host.oBUSY     = busy;
  assign host.oNACK_CNT = nack_q;

endmodule

// File: tb/tb_i2c_codec_responder.sv
`timescale 1ns/1ps
module tb_i2c_codec_responder;

  localparam int Q = 4;  // quarter SCL period in iCLK cycles

  logic iCLK = 1'b0;
  logic iRST;
  logic scl;
  logic m_sda_low;
  wire  sda;

  pullup (sda);
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  i2c_codec_responder_if host_if ();

  i2c_codec_responder #(
    .DEV_ADDR (7'h1A),
    .NREGS    (16),
    .RST_REG  (7'h0F)
  ) dut (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .I2C_SCLK (scl),
    .I2C_SDAT (sda),
    .host     (host_if)
  );

  always #10 iCLK = ~iCLK;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitors, sampled shortly after the falling edge.
  int         stb_cnt      = 0;
  int         dut_low_cnt  = 0;
  logic       stb_d        = 1'b0;
  logic [8:0] rd_at_stb    = '0;
  logic [8:0] rd_after_stb = '0;

  always begin
    @(negedge iCLK);
    #2;
    if (host_if.oWR_STB) begin
      stb_cnt   <= stb_cnt + 1;
      rd_at_stb <= host_if.oRD_DATA;
    end
    if (stb_d) rd_after_stb <= host_if.oRD_DATA;
    stb_d <= host_if.oWR_STB;
    if ((sda === 1'b0) && !m_sda_low) dut_low_cnt <= dut_low_cnt + 1;
  end

  initial begin
    #4ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  task automatic bit_out(input logic b);
    m_sda_low = ~b; wait_n(Q);
    scl = 1'b1;     wait_n(2*Q);
    scl = 1'b0;     wait_n(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) bit_out(b[i]);
    m_sda_low = 1'b0; wait_n(Q);
    scl = 1'b1;       wait_n(Q);
    ack = (sda === 1'b0);
    wait_n(Q);
    scl = 1'b0;       wait_n(Q);
  endtask

  task automatic bus_start();
    m_sda_low = 1'b0; wait_n(Q);
    scl = 1'b1;       wait_n(Q);
    m_sda_low = 1'b1; wait_n(Q);
    scl = 1'b0;       wait_n(Q);
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1; wait_n(Q);
    scl = 1'b1;       wait_n(Q);
    m_sda_low = 1'b0; wait_n(Q);
  endtask

  task automatic write3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        output logic [2:0] acks);
    bus_start();
    send_byte(b0, acks[2]);
    send_byte(b1, acks[1]);
    send_byte(b2, acks[0]);
    bus_stop();
    wait_n(2);
  endtask

  task automatic rd_check(input string tag, input logic [3:0] a, input logic [8:0] exp);
    host_if.iRD_ADDR = a;
    wait_n(1);
    check_eq(tag, 32'(host_if.oRD_DATA), 32'(exp));
  endtask

  initial begin
    logic [2:0] acks;
    logic       a;
    int         s0, d0;

    iRST = 1'b1; scl = 1'b1; m_sda_low = 1'b0; host_if.iRD_ADDR = 4'd0;
    wait_n(5);
    iRST = 1'b0;
    wait_n(2);

    // Reset state
    check_eq("rst_stb",   32'(host_if.oWR_STB),   0);
    check_eq("rst_raddr", 32'(host_if.oREG_ADDR), 0);
    check_eq("rst_rdata", 32'(host_if.oREG_DATA), 0);
    check_eq("rst_busy",  32'(host_if.oBUSY),     0);
    check_eq("rst_nack",  32'(host_if.oNACK_CNT), 0);
    check_eq("rst_rd",    32'(host_if.oRD_DATA),  0);
    check_eq("rst_sda",   32'(sda),               1);

    // Basic write: reg 6 <- 0x007, readback watched across the commit
    host_if.iRD_ADDR = 4'd6;
    s0 = stb_cnt;
    bus_start();
    send_byte(8'h34, acks[2]);
    check_eq("busy_mid", 32'(host_if.oBUSY), 1);
    send_byte(8'h0C, acks[1]);
    send_byte(8'h07, acks[0]);
    bus_stop();
    wait_n(2);
    check_eq("w6_acks",    32'(acks), 32'h7);
    check_eq("w6_stb",     32'(stb_cnt - s0), 1);
    check_eq("w6_raddr",   32'(host_if.oREG_ADDR), 6);
    check_eq("w6_rdata",   32'(host_if.oREG_DATA), 32'h007);
    check_eq("w6_busy",    32'(host_if.oBUSY), 0);
    check_eq("rd_old",     32'(rd_at_stb), 0);
    check_eq("rd_new",     32'(rd_after_stb), 32'h007);
    rd_check("rd6", 4'd6, 9'h007);

    // Data bit 8 from the REG byte: reg 2 <- 0x1FF
    write3(8'h34, 8'h05, 8'hFF, acks);
    check_eq("w2_acks",  32'(acks), 32'h7);
    check_eq("w2_raddr", 32'(host_if.oREG_ADDR), 2);
    rd_check("rd2", 4'd2, 9'h1FF);

    // Foreign address: silent
    s0 = stb_cnt; d0 = dut_low_cnt;
    bus_start();
    send_byte(8'h36, acks[1]);
    send_byte(8'h0C, acks[0]);
    bus_stop();
    wait_n(2);
    check_eq("frn_acks", 32'(acks[1:0]), 0);
    check_eq("frn_drv",  32'(dut_low_cnt - d0), 0);
    check_eq("frn_stb",  32'(stb_cnt - s0), 0);
    check_eq("frn_nack", 32'(host_if.oNACK_CNT), 0);

    // Read request: NACK, counted once, rest ignored
    s0 = stb_cnt;
    bus_start();
    send_byte(8'h35, a);
    check_eq("rd_req_ack",  32'(a), 0);
    check_eq("rd_req_nack", 32'(host_if.oNACK_CNT), 1);
    send_byte(8'h0C, a);
    check_eq("rd_ign_ack",  32'(a), 0);
    bus_stop();
    wait_n(2);
    check_eq("rd_ign_stb",  32'(stb_cnt - s0), 0);
    check_eq("rd_ign_nack", 32'(host_if.oNACK_CNT), 1);

    // Reg 3 <- 0x055, then the clear-all register
    write3(8'h34, 8'h06, 8'h55, acks);
    rd_check("rd3", 4'd3, 9'h055);
    s0 = stb_cnt;
    write3(8'h34, 8'h1E, 8'h00, acks);
    check_eq("clr_acks",  32'(acks), 32'h7);
    check_eq("clr_stb",   32'(stb_cnt - s0), 1);
    check_eq("clr_raddr", 32'(host_if.oREG_ADDR), 32'h0F);
    check_eq("clr_rdata", 32'(host_if.oREG_DATA), 0);
    for (int i = 0; i < 16; i++) rd_check($sformatf("clr_rd%0d", i), 4'(i), 9'h000);

    // Out-of-range register address
    bus_start();
    send_byte(8'h34, a);
    send_byte(8'h20, a);
    check_eq("oor_ack", 32'(a), 0);
    bus_stop();
    wait_n(2);
    check_eq("oor_nack", 32'(host_if.oNACK_CNT), 2);

    // Highest ordinary register: reg 14 <- 0x180
    write3(8'h34, 8'h1D, 8'h80, acks);
    check_eq("w14_acks", 32'(acks), 32'h7);
    rd_check("rd14", 4'd14, 9'h180);

    // Fourth byte after a complete write
    s0 = stb_cnt;
    bus_start();
    send_byte(8'h34, acks[2]);
    send_byte(8'h0C, acks[1]);
    send_byte(8'h07, acks[0]);
    send_byte(8'h5A, a);
    bus_stop();
    wait_n(2);
    check_eq("x4_acks", 32'(acks), 32'h7);
    check_eq("x4_ack",  32'(a), 0);
    check_eq("x4_nack", 32'(host_if.oNACK_CNT), 3);
    check_eq("x4_stb",  32'(stb_cnt - s0), 1);

    // Repeated START after the REG byte discards the partial write
    s0 = stb_cnt;
    bus_start();
    send_byte(8'h34, a);
    send_byte(8'h0A, a);
    bus_start();
    send_byte(8'h34, acks[2]);
    send_byte(8'h08, acks[1]);
    send_byte(8'h33, acks[0]);
    bus_stop();
    wait_n(2);
    check_eq("rs_acks", 32'(acks), 32'h7);
    check_eq("rs_stb",  32'(stb_cnt - s0), 1);
    rd_check("rs_rd4", 4'd4, 9'h033);
    rd_check("rs_rd5", 4'd5, 9'h000);

    // Reset while the responder is pulling SDA for the address ACK
    host_if.iRD_ADDR = 4'd4;
    bus_start();
    for (int i = 7; i >= 0; i--) bit_out(1'((8'h34 >> i) & 8'h01));
    m_sda_low = 1'b0;
    #1;
    check_eq("ack_drv", 32'(sda), 0);
    iRST = 1'b1;
    #1;
    check_eq("rst_rel", 32'(sda), 1);
    wait_n(1);
    check_eq("mr_stb",   32'(host_if.oWR_STB),   0);
    check_eq("mr_raddr", 32'(host_if.oREG_ADDR), 0);
    check_eq("mr_rdata", 32'(host_if.oREG_DATA), 0);
    check_eq("mr_busy",  32'(host_if.oBUSY),     0);
    check_eq("mr_nack",  32'(host_if.oNACK_CNT), 0);
    check_eq("mr_rd",    32'(host_if.oRD_DATA),  0);
    iRST = 1'b0;
    s0 = stb_cnt; d0 = dut_low_cnt;
    wait_n(Q - 1);
    scl = 1'b1; wait_n(2*Q);
    scl = 1'b0; wait_n(Q);
    send_byte(8'h0C, acks[1]);
    send_byte(8'h07, acks[0]);
    bus_stop();
    wait_n(2);
    check_eq("mr_acks", 32'(acks[1:0]), 0);
    check_eq("mr_nostb", 32'(stb_cnt - s0), 0);
    check_eq("mr_nodrv", 32'(dut_low_cnt - d0), 0);
    rd_check("mr_rd4", 4'd4, 9'h000);

    // A fresh frame is accepted again
    write3(8'h34, 8'h0C, 8'h07, acks);
    check_eq("post_acks", 32'(acks), 32'h7);
    check_eq("post_stb",  32'(stb_cnt - s0), 1);
    rd_check("post_rd6", 4'd6, 9'h007);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
